// File: rtl/filter_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// filter_bank_ctrl_if
//
// Groups the filter-select request, the three filter sample inputs and all
// controller outputs into one bundle.
//
// Modports
//   slave  : the controller side (filter_bank_ctrl).
//   master : the driving/observing side (system or bench).
//
// Signals
//   i_sel[1:0]      filter request: 0=FIR, 1=CIC, 2=IIR, 3=off
//   i_sel_stb       one-cycle strobe qualifying i_sel
//   i_fir_data      signed FIR sample (DATA_W)
//   i_cic_data      signed CIC sample (CIC_W)
//   i_iir_data      signed IIR sample (DATA_W)
//   o_fir_en/o_cic_en/o_iir_en   registered filter enables
//   o_data          signed selected sample (DATA_W)
//   o_valid         one-cycle qualifier for o_data
//   o_busy          high while the bank is flushing
//   o_active_sel    committed selection (3 = off)
//   o_peak          peak |o_data| (only with FILTER_BANK_CTRL_PEAK_EN)
// ---------------------------------------------------------------------------
interface filter_bank_ctrl_if #(
    parameter int DATA_W = 28,
    parameter int CIC_W  = 20
);
    logic [1:0]        i_sel;
    logic              i_sel_stb;
    logic [DATA_W-1:0] i_fir_data;
    logic [CIC_W-1:0]  i_cic_data;
    logic [DATA_W-1:0] i_iir_data;

    logic              o_fir_en;
    logic              o_cic_en;
    logic              o_iir_en;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_busy;
    logic [1:0]        o_active_sel;

`ifdef FILTER_BANK_CTRL_PEAK_EN
    logic [DATA_W-1:0] o_peak;

    modport slave (
        input  i_sel, i_sel_stb, i_fir_data, i_cic_data, i_iir_data,
        output o_fir_en, o_cic_en, o_iir_en, o_data, o_valid, o_busy,
               o_active_sel, o_peak
    );

    modport master (
        output i_sel, i_sel_stb, i_fir_data, i_cic_data, i_iir_data,
        input  o_fir_en, o_cic_en, o_iir_en, o_data, o_valid, o_busy,
               o_active_sel, o_peak
    );
`else
    modport slave (
        input  i_sel, i_sel_stb, i_fir_data, i_cic_data, i_iir_data,
        output o_fir_en, o_cic_en, o_iir_en, o_data, o_valid, o_busy,
               o_active_sel
    );

    modport master (
        output i_sel, i_sel_stb, i_fir_data, i_cic_data, i_iir_data,
        input  o_fir_en, o_cic_en, o_iir_en, o_data, o_valid, o_busy,
               o_active_sel
    );
`endif
endinterface

// File: rtl/filter_bank_ctrl.sv
// ---------------------------------------------------------------------------
// filter_bank_ctrl
//
// Selects one of three filters (FIR, CIC, IIR), enables only that filter,
// lets it settle for SETTLE_CYCLES cycles after every switch, then forwards
// its samples. FIR/IIR samples are forwarded every cycle; CIC samples are
// decimated by CIC_DECIM and sign-extended to DATA_W.
//
// Ports
//   i_clk    : clock, all state changes on the rising edge
//   i_reset  : asynchronous, active-low reset
//   bus      : filter_bank_ctrl_if.slave (request, samples, outputs)
//
// Optional feature
//   FILTER_BANK_CTRL_PEAK_EN : adds bus.o_peak, the peak |o_data| seen since
//   the last flush entry (most-negative value saturates to max positive).
// ---------------------------------------------------------------------------
module filter_bank_ctrl #(
    parameter int DATA_W        = 28,
    parameter int CIC_W         = 20,
    parameter int SETTLE_CYCLES = 64,
    parameter int CIC_DECIM     = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    filter_bank_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [1:0]  SEL_FIR     = 2'd0;
    localparam logic [1:0]  SEL_CIC     = 2'd1;
    localparam logic [1:0]  SEL_IIR     = 2'd2;
    localparam logic [1:0]  SEL_OFF     = 2'd3;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  DECIM_LAST  = 8'(CIC_DECIM - 1);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       settle_q, settle_d;
    logic [7:0]        decim_q, decim_d;
    logic [2:0]        en_q, en_d;       // {iir, cic, fir}
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              flush_entry;
    logic [DATA_W-1:0] cic_ext;

    assign cic_ext = {{(DATA_W-CIC_W){bus.i_cic_data[CIC_W-1]}}, bus.i_cic_data};

    // Next-state logic. Enables, o_valid and o_data are all computed from
    // the next state so that they are registered and line up with the state
    // they belong to; flush_entry marks every (re)start of the settle period.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        flush_entry = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_sel_stb && bus.i_sel != SEL_OFF) begin
                    state_d     = FLUSH;
                    sel_d       = bus.i_sel;
                    flush_entry = 1'b1;
                end
            end
            FLUSH: begin
                if (bus.i_sel_stb) begin
                    if (bus.i_sel == SEL_OFF) begin
                        state_d = IDLE;
                        sel_d   = SEL_OFF;
                    end else begin
                        sel_d       = bus.i_sel;
                        flush_entry = 1'b1;
                    end
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.i_sel_stb && bus.i_sel != sel_q) begin
                    if (bus.i_sel == SEL_OFF) begin
                        state_d = IDLE;
                        sel_d   = SEL_OFF;
                    end else begin
                        state_d     = FLUSH;
                        sel_d       = bus.i_sel;
                        flush_entry = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = SEL_OFF;
            end
        endcase

        settle_d = '0;
        if (state_d == FLUSH && !flush_entry) begin
            settle_d = settle_q + 16'd1;
        end

        // The decimation count restarts at 0 whenever RUN is (re)entered.
        decim_d = '0;
        if (state_q == RUN && state_d == RUN && sel_q == SEL_CIC) begin
            decim_d = (decim_q == DECIM_LAST) ? 8'd0 : decim_q + 8'd1;
        end

        en_d = 3'b000;
        if (state_d != IDLE) begin
            case (sel_d)
                SEL_FIR: en_d = 3'b001;
                SEL_CIC: en_d = 3'b010;
                SEL_IIR: en_d = 3'b100;
                default: en_d = 3'b000;
            endcase
        end

        valid_d = (state_d == RUN) && (sel_d != SEL_CIC || decim_d == 8'd0);

        data_d = data_q;
        if (valid_d) begin
            case (sel_d)
                SEL_CIC: data_d = cic_ext;
                SEL_IIR: data_d = bus.i_iir_data;
                default: data_d = bus.i_fir_data;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            sel_q    <= SEL_OFF;
            settle_q <= '0;
            decim_q  <= '0;
            en_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            settle_q <= settle_d;
            decim_q  <= decim_d;
            en_q     <= en_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.o_fir_en     = en_q[0];
    assign bus.o_cic_en     = en_q[1];
    assign bus.o_iir_en     = en_q[2];
    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_busy       = (state_q == FLUSH);
    assign bus.o_active_sel = sel_q;

`ifdef FILTER_BANK_CTRL_PEAK_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] peak_q, peak_d, mag_d;

    // Magnitude of the sample being registered this cycle; the most-negative
    // code has no positive counterpart and saturates instead.
    always_comb begin
        mag_d = data_d;
        if (data_d[DATA_W-1]) begin
            mag_d = (data_d == MOST_NEG) ? MAX_POS : (~data_d + 1'b1);
        end
        peak_d = peak_q;
        if (flush_entry) begin
            peak_d = '0;
        end else if (valid_d && mag_d > peak_q) begin
            peak_d = mag_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign bus.o_peak = peak_q;
`endif

endmodule

// File: doc/filter_bank_ctrl.md
FILTER_BANK_CTRL -- requirements
Module: filter_bank_ctrl

Interface
REQ-001 Parameter DATA_W, default 28, width of the FIR/IIR data and of the output data.
REQ-002 Parameter CIC_W, default 20, width of the CIC data.
REQ-003 Parameter SETTLE_CYCLES, default 64, number of flush cycles after a filter switch (range 1..65535).
REQ-004 Parameter CIC_DECIM, default 8, CIC output decimation ratio (range 2..256).
REQ-005 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_sel  in  2  filter request: 0=FIR, 1=CIC, 2=IIR, 3=off.
REQ-008 i_sel_stb  in  1  one-cycle strobe; samples i_sel.
REQ-009 i_fir_data  in  DATA_W  signed FIR output.
REQ-010 i_cic_data  in  CIC_W  signed CIC output.
REQ-011 i_iir_data  in  DATA_W  signed IIR output.
REQ-012 o_fir_en / o_cic_en / o_iir_en  out  1 each  filter enables.
REQ-013 o_data  out  DATA_W  signed selected sample.
REQ-014 o_valid  out  1  one-cycle qualifier for o_data.
REQ-015 o_busy  out  1  high while in FLUSH.
REQ-016 o_active_sel  out  2  currently committed selection (3 = off).

Function
REQ-020 FSM states: IDLE, FLUSH, RUN.
REQ-021 IDLE: all enables 0; o_valid 0.
- Strobe with i_sel in 0..2 -> FLUSH.
- Strobe with i_sel = 3 -> ignored.
REQ-022 FLUSH: only the requested enable is 1; o_busy 1; o_valid 0; a settle counter counts SETTLE_CYCLES cycles, then the FSM enters RUN.
REQ-023 RUN: the selected enable is 1; the other enables are 0.
REQ-024 In RUN with FIR or IIR selected, o_data is registered from the selected input with 1-cycle latency, and o_valid is 1 every cycle.
REQ-025 In RUN with CIC selected, a decimation counter runs 0..CIC_DECIM-1; o_valid pulses when the counter reaches 0 (first pulse on the first RUN cycle); o_data is i_cic_data sign-extended to DATA_W.
REQ-026 o_data holds its last value whenever o_valid is 0.
REQ-027 Strobe in RUN with i_sel equal to o_active_sel: ignored.
- Strobe with a different value in 0..2 -> FLUSH.
- Strobe with i_sel = 3 -> IDLE next cycle.
REQ-028 Strobe in FLUSH: latest request wins.
- Value 0..2: the settle counter restarts from 0 and the enables switch next cycle.
- Value 3: IDLE.
REQ-029 o_active_sel updates on the cycle the FSM enters FLUSH or IDLE.
REQ-030 Enables are registered: no enable glitches, and never more than one enable high.
REQ-031 The decimation counter resets to 0 on every entry into RUN.

Reset
REQ-040 While i_reset=0, and immediately on assertion:
- State is IDLE.
- All enables are 0.
- o_data=0, o_valid=0, o_busy=0, o_active_sel=3.
- Both counters are 0.
REQ-041 Reset assertion mid-FLUSH or mid-RUN aborts the operation with no further o_valid pulse.
REQ-042 The first strobe is accepted on the first rising edge after deassertion.

Configuration
REQ-050 Macro FILTER_BANK_CTRL_PEAK_EN defined: adds output o_peak (DATA_W, unsigned).
- o_peak holds the maximum |o_data| over all valid samples since the last FLUSH entry.
- o_peak is cleared to 0 on FLUSH entry and on reset.
- |most-negative value| saturates to 2^(DATA_W-1)-1.
REQ-051 Macro undefined: port o_peak and its logic are absent; all other behaviour is identical.

Verification
REQ-060 Reset released, strobe i_sel=0 at cycle 5 -> o_fir_en=1 and o_busy=1 from cycle 6; first o_valid at cycle 6+64; o_data equals i_fir_data of the previous cycle.
REQ-061 In RUN on CIC, i_cic_data=20'hFFFFF -> o_data=28'hFFFFFFF; o_valid is high on exactly 1 of every 8 cycles.
REQ-062 Strobe i_sel=2 at flush cycle 30, then i_sel=1 at flush cycle 40 -> the enable moves IIR then CIC; RUN starts 64 cycles after the second strobe; no o_valid during flush.
REQ-063 In RUN on IIR: strobe i_sel=2 -> no change; strobe i_sel=3 -> all enables 0 next cycle, o_active_sel=3, o_data held.
REQ-064 i_reset pulsed low mid-RUN -> all outputs return to their reset values asynchronously; no o_valid is produced until a new strobe plus 64 cycles.
REQ-065 With PEAK_EN, FIR samples 100, -300, 200 -> o_peak=300; the next switch clears o_peak to 0.
